// File: rtl/td4x_control.sv
// Sequencer for a TD4-style 4-bit CPU: fetches, decodes and executes one instruction at a time,
// driving datapath selects, register write strobes, PC strobes and ready/valid I/O handshakes.
module td4x_control #(
  parameter int NREG           = 2,
  parameter bit HALT_ON_UNUSED = 1'b0,
  localparam int RW            = (NREG <= 2) ? 1 : $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req,
  input  logic            instr_valid,
  input  logic [3:0]      instr_op,
  input  logic [RW-1:0]   instr_rd,
  input  logic [RW-1:0]   instr_rs,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [1:0]      src_sel,
  output logic [RW-1:0]   rs_sel,
  output logic [NREG-1:0] reg_we,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            in_ready,
  input  logic            in_valid,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            resume,
  output logic            halted,
  output logic            c_flag,
  output logic            z_flag
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_WAIT_IN, S_WAIT_OUT, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_RS = 4'b0001;
  localparam logic [3:0] OP_IN     = 4'b0010;
  localparam logic [3:0] OP_MOV_IM = 4'b0011;
  localparam logic [3:0] OP_ADD_RS = 4'b0100;
  localparam logic [3:0] OP_OUT_RS = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_HLT    = 4'b1100;
  localparam logic [3:0] OP_JZ     = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [RW-1:0]   rs_q, rs_d;
  logic            c_q, c_d;
  logic            z_q, z_d;
  logic            we;

  function automatic logic [RW-1:0] mod_nreg(input logic [RW-1:0] v);
    return RW'(int'(v) % NREG);
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    c_d       = c_q;
    z_d       = z_q;
    fetch_req = 1'b0;
    we        = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;

    case (op_q)
      OP_ADD_IM, OP_ADD_RS:                        src_sel = 2'b00;
      OP_MOV_RS, OP_OUT_RS:                        src_sel = 2'b01;
      OP_IN:                                       src_sel = 2'b10;
      OP_MOV_IM, OP_OUT_IM, OP_JZ, OP_JNC, OP_JMP: src_sel = 2'b11;
      default:                                     src_sel = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = mod_nreg(instr_rd);
          rs_d    = mod_nreg(instr_rs);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_ADD_IM, OP_ADD_RS: begin
            we     = 1'b1;
            pc_inc = 1'b1;
            c_d    = alu_c;
            z_d    = alu_z;
          end
          OP_MOV_RS, OP_MOV_IM: begin
            we     = 1'b1;
            pc_inc = 1'b1;
            c_d    = 1'b0;
          end
          OP_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
              we     = 1'b1;
              pc_inc = 1'b1;
              c_d    = 1'b0;
            end else begin
              state_d = S_WAIT_IN;
            end
          end
          OP_OUT_RS, OP_OUT_IM: begin
            out_valid = 1'b1;
            if (out_ready) begin
              pc_inc = 1'b1;
              c_d    = 1'b0;
            end else begin
              state_d = S_WAIT_OUT;
            end
          end
          OP_HLT:  state_d = S_HALT;
          OP_JZ:   begin pc_load = z_q;  pc_inc = ~z_q; end
          OP_JNC:  begin pc_load = ~c_q; pc_inc = c_q;  end
          OP_JMP:  pc_load = 1'b1;
          default: begin
            if (HALT_ON_UNUSED) state_d = S_HALT;
            else                pc_inc  = 1'b1;
          end
        endcase
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we      = 1'b1;
          pc_inc  = 1'b1;
          c_d     = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_inc  = 1'b1;
          c_d     = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobe is one-hot on the latched destination, which is already reduced modulo NREG.
  always_comb begin
    reg_we = '0;
    for (int i = 0; i < NREG; i++) reg_we[i] = we && (rd_q == RW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  assign rs_sel = rs_q;
  assign c_flag = c_q;
  assign z_flag = z_q;

endmodule
